// File: rtl/hyp_cordic_pkg.sv
// Shared constants for the hyperbolic radix-N rotation stage: gain table,
// rotation-index width and the saturating absolute-value helper.
package hyp_cordic_pkg;

   localparam int ROT_W     = 6;
   localparam int ROT_MAX   = (1 << ROT_W) - 1;
   localparam int ABS_MAX_W = 32;

   // Gain table 1/sqrt(1-2^-2t) held in Q1.31; users truncate to their own width.
   localparam int KTAB_W    = 32;
   localparam int KTAB_FW   = 31;
   localparam int KTAB_LAST = 63;
   localparam logic [KTAB_W-1:0] KTAB_ONE = 32'h8000_0000;

   localparam logic [KTAB_W-1:0] KTAB_Q31 [0:KTAB_LAST] = '{
      1:       32'd2479700524,
      2:       32'd2217911574,
      3:       32'd2164460067,
      4:       32'd2151690280,
      5:       32'd2148532992,
      6:       32'd2147745840,
      7:       32'd2147549187,
      8:       32'd2147500032,
      9:       32'd2147487744,
      10:      32'd2147484672,
      11:      32'd2147483904,
      12:      32'd2147483712,
      13:      32'd2147483664,
      14:      32'd2147483652,
      15:      32'd2147483649,
      default: 32'd2147483648
   };

   // |v| for a w-bit signed value carried sign-extended in ABS_MAX_W bits;
   // the most-negative w-bit value saturates to 2^(w-1)-1.
   function automatic logic [ABS_MAX_W-1:0] sat_abs(
      input logic signed [ABS_MAX_W-1:0] v,
      input int unsigned                 w
   );
      logic [ABS_MAX_W-1:0] lo;
      lo = {ABS_MAX_W{1'b1}} << (w - 1);
      if (v == signed'(lo))
         return ~lo;
      else if (v < 0)
         return unsigned'(-v);
      else
         return unsigned'(v);
   endfunction

endpackage

// File: rtl/hyperbola_radixn_rotation_stage_if.sv
// Operand/result bundle of the rotation stage; the stage itself uses the slave side.
interface hyperbola_radixn_rotation_stage_if
   import hyp_cordic_pkg::*;
#(
   parameter int DSIZE = 17
);
   logic                    in_valid;
   logic [DSIZE-1:0]        IX;
   logic signed [DSIZE-1:0] IY;
   logic [ROT_W-1:0]        rotation;
   logic [DSIZE-1:0]        K;

   logic                    out_valid;
   logic [DSIZE-1:0]        OX;
   logic signed [DSIZE-1:0] OY;
   logic [ROT_W-1:0]        next_rott;
   logic [DSIZE-1:0]        next_K;
   logic                    done;

   modport master (
      output in_valid, IX, IY, rotation, K,
      input  out_valid, OX, OY, next_rott, next_K, done
   );

   modport slave (
      input  in_valid, IX, IY, rotation, K,
      output out_valid, OX, OY, next_rott, next_K, done
   );
endinterface

// File: rtl/hyp_kcoeff_rom.sv
// Registered lookup of the LOOKAHEAD gain coefficients for shifts r..r+LOOKAHEAD-1,
// scaled to Q1.(DSIZE-1); shifts beyond RMAX read as 1.0.
module hyp_kcoeff_rom
   import hyp_cordic_pkg::*;
#(
   parameter int DSIZE     = 17,
   parameter int LOOKAHEAD = 4,
   parameter int RMAX      = 20
)(
   input  logic                              clock,
   input  logic [ROT_W-1:0]                  i_rotation,
   output logic [LOOKAHEAD-1:0][DSIZE-1:0]   o_coef
);

   function automatic logic [DSIZE-1:0] coef_at(input int t);
      logic [KTAB_W-1:0] q;
      if (t > RMAX || t > KTAB_LAST)
         q = KTAB_ONE;
      else
         q = KTAB_Q31[t[ROT_W-1:0]];
      q = q >> (KTAB_FW - (DSIZE - 1));
      return q[DSIZE-1:0];
   endfunction

   // NOTE: no reset here; coefficients are pure data and only matter when the
   // valid pipeline says so, so resetting them would add logic for nothing.
   always_ff @(posedge clock) begin
      for (int j = 0; j < LOOKAHEAD; j++)
         o_coef[j] <= coef_at(int'(i_rotation) + j);
   end

endmodule

// File: rtl/hyperbola_radixn_rotation_stage.sv
// Three-cycle hyperbolic rotation stage trying LOOKAHEAD shifts at once.
// Gain scaling is built only when HYP_ROT_KSCALE_EN is defined.
module hyperbola_radixn_rotation_stage
   import hyp_cordic_pkg::*;
#(
   parameter int DSIZE     = 17,
   parameter int LOOKAHEAD = 4,
   parameter int RMAX      = 20
)(
   input logic                              clock,
   input logic                              rst,
   hyperbola_radixn_rotation_stage_if.slave bus
);

   localparam int TW = ROT_W + 2;
   localparam int SW = ROT_W + 4;

   // ---------------- stage 1: register operands, |IY|, IX>>r ----------------
   logic signed [ABS_MAX_W-1:0] w_iy_ext;
   logic [ABS_MAX_W-1:0]        w_iy_abs;
   logic                        w_unused_abs;

   assign w_iy_ext     = {{(ABS_MAX_W-DSIZE){bus.IY[DSIZE-1]}}, bus.IY};
   assign w_iy_abs     = sat_abs(w_iy_ext, DSIZE);
   assign w_unused_abs = ^w_iy_abs[ABS_MAX_W-1:DSIZE];

   logic             r_v1;
   logic [DSIZE-1:0] r_x1, r_y1, r_ay1, r_xsh1, r_k1;
   logic [ROT_W-1:0] r_r1;

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples the pre-edge value of its neighbours regardless of process order.
   always_ff @(posedge clock) begin
      if (rst) r_v1 <= 1'b0;
      else     r_v1 <= bus.in_valid;
   end

   always_ff @(posedge clock) begin
      r_x1   <= bus.IX;
      r_y1   <= bus.IY;
      r_ay1  <= w_iy_abs[DSIZE-1:0];
      r_xsh1 <= bus.IX >> bus.rotation;
      r_r1   <= bus.rotation;
      r_k1   <= bus.K;
   end

`ifdef HYP_ROT_KSCALE_EN
   logic [LOOKAHEAD-1:0][DSIZE-1:0] w_coef1, r_coef2;

   hyp_kcoeff_rom #(
      .DSIZE     (DSIZE),
      .LOOKAHEAD (LOOKAHEAD),
      .RMAX      (RMAX)
   ) u_kcoeff_rom (
      .clock      (clock),
      .i_rotation (bus.rotation),
      .o_coef     (w_coef1)
   );
`endif

   // ---------------- stage 2: qualify candidates, build X/Y ----------------
   logic [LOOKAHEAD-1:0][TW-1:0]    w_t;
   logic [LOOKAHEAD-1:0][DSIZE-1:0] w_xs, w_cx, w_cy;
   logic [LOOKAHEAD-1:0]            w_q;

   // NOTE: every always_comb output gets a default first so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      w_t  = '0;
      w_xs = '0;
      w_cx = '0;
      w_cy = '0;
      w_q  = '0;
      for (int j = 0; j < LOOKAHEAD; j++) begin
         w_t[j]  = TW'(r_r1) + TW'(j);
         w_xs[j] = r_xsh1 >> j;
         w_q[j]  = (w_xs[j] != '0) && (r_ay1 >= w_xs[j]);
         w_cx[j] = r_x1 - (r_ay1 >> w_t[j]);
         w_cy[j] = r_y1[DSIZE-1] ? (r_y1 + w_xs[j]) : (r_y1 - w_xs[j]);
      end
   end

   logic                            r_v2;
   logic [DSIZE-1:0]                r_x2, r_y2, r_k2;
   logic [ROT_W-1:0]                r_r2;
   logic [LOOKAHEAD-1:0]            r_q2;
   logic [LOOKAHEAD-1:0][DSIZE-1:0] r_cx2, r_cy2;

   always_ff @(posedge clock) begin
      if (rst) r_v2 <= 1'b0;
      else     r_v2 <= r_v1;
   end

   always_ff @(posedge clock) begin
      r_x2  <= r_x1;
      r_y2  <= r_y1;
      r_k2  <= r_k1;
      r_r2  <= r_r1;
      r_q2  <= w_q;
      r_cx2 <= w_cx;
      r_cy2 <= w_cy;
`ifdef HYP_ROT_KSCALE_EN
      r_coef2 <= w_coef1;
`endif
   end

   // ---------------- stage 3: pick smallest qualifying j, scale K ----------------
   logic [DSIZE-1:0] w_ox, w_oy, w_next_k;
   logic [SW-1:0]    w_step, w_sum;
   logic [ROT_W-1:0] w_rott;
   logic             w_done;
`ifdef HYP_ROT_KSCALE_EN
   logic [DSIZE-1:0] w_sel_coef;
`endif

   // Scanning downward lets the smallest qualifying j overwrite the others.
   always_comb begin
      w_ox   = r_x2;
      w_oy   = r_y2;
      w_step = SW'(LOOKAHEAD + 1);
`ifdef HYP_ROT_KSCALE_EN
      w_sel_coef = DSIZE'(1) << (DSIZE - 1);
`endif
      for (int j = LOOKAHEAD - 1; j >= 0; j--) begin
         if (r_q2[j]) begin
            w_ox   = r_cx2[j];
            w_oy   = r_cy2[j];
            w_step = SW'(j + 1);
`ifdef HYP_ROT_KSCALE_EN
            w_sel_coef = r_coef2[j];
`endif
         end
      end
      w_sum  = SW'(r_r2) + w_step;
      w_rott = (w_sum > SW'(ROT_MAX)) ? ROT_W'(ROT_MAX) : w_sum[ROT_W-1:0];
   end

`ifdef HYP_ROT_KSCALE_EN
   localparam int PW = 2 * DSIZE;
   logic [PW-1:0] w_prod;
   logic          w_unused_prod;

   assign w_prod        = PW'(r_k2) * PW'(w_sel_coef);
   assign w_next_k      = w_prod[PW-2:DSIZE-1];
   assign w_unused_prod = ^{w_prod[PW-1], w_prod[DSIZE-2:0]};
`else
   assign w_next_k = r_k2;
`endif

   assign w_done = int'(w_rott) > RMAX;

   logic             r_v3, r_done;
   logic [DSIZE-1:0] r_ox, r_oy, r_nk;
   logic [ROT_W-1:0] r_nr;

   // Results only move on a valid beat, so bubbles leave the last result visible.
   always_ff @(posedge clock) begin
      if (rst) begin
         r_v3   <= 1'b0;
         r_ox   <= '0;
         r_oy   <= '0;
         r_nr   <= '0;
         r_nk   <= '0;
         r_done <= 1'b0;
      end else begin
         r_v3 <= r_v2;
         if (r_v2) begin
            r_ox   <= w_ox;
            r_oy   <= w_oy;
            r_nr   <= w_rott;
            r_nk   <= w_next_k;
            r_done <= w_done;
         end
      end
   end

   assign bus.out_valid = r_v3;
   assign bus.OX        = r_ox;
   assign bus.OY        = r_oy;
   assign bus.next_rott = r_nr;
   assign bus.next_K    = r_nk;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_hyperbola_radixn_rotation_stage.sv
// Directed bench for hyperbola_radixn_rotation_stage (DSIZE=17, LOOKAHEAD=4, RMAX=20);
// expected gains follow HYP_ROT_KSCALE_EN when it is defined.
module tb_hyperbola_radixn_rotation_stage;

   logic clock;
   logic rst;
   int   n_total = 0;
   int   n_bad   = 0;

   hyperbola_radixn_rotation_stage_if #(.DSIZE(17)) bus ();

   hyperbola_radixn_rotation_stage #(
      .DSIZE     (17),
      .LOOKAHEAD (4),
      .RMAX      (20)
   ) dut (
      .clock (clock),
      .rst   (rst),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "bench did not terminate");
   end

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   // nk is the scaled gain; without the gain feature next_K is just K delayed.
   typedef struct {
      int ix, iy, r, k;
      int ox, oy, nr, nk, dn;
   } vec_t;

   vec_t vecs [12] = '{
      '{65536,  32768,  1, 65536, 49152,      0,  2, 75674, 0},
      '{65536, -32768,  1, 65536, 49152,      0,  2, 75674, 0},
      '{65536,    100,  1, 70000, 65536,    100,  6, 70000, 0},
      '{65536, -65536,  1, 65536, 32769, -32768,  2, 75674, 0},
      '{65536,  65535,  0, 40000, 32769,  32767,  2, 46187, 0},
      '{60000,  -5000,  3, 65536, 59688,  -1250,  5, 65664, 0},
      '{65536,   9000,  1, 65536, 64411,    808,  4, 66054, 0},
      '{65536,      1, 16, 70000, 65536,      0, 17, 70000, 0},
      '{50000,      0, 15, 12345, 50000,      0, 20, 12345, 0},
      '{50000,      0, 16, 12345, 50000,      0, 21, 12345, 1},
      '{65536,      0, 62,   100, 65536,      0, 63,   100, 1},
      '{65536,      0, 58,   100, 65536,      0, 63,   100, 1}
   };

   bit vin  [16] = '{1,1,1,1,1,1,0,1,1,1,1,0,0,0,0,0};
   bit vrst [16] = '{0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0};

   function automatic bit exp_valid(input int n);
      if (n < 3) return 1'b0;
      return vin[n-3] && !vrst[n-3] && !vrst[n-2] && !vrst[n-1];
   endfunction

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int exp_k;
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.IX       = 17'd65536;
      bus.IY       = 17'sd32768;
      bus.rotation = 6'd1;
      bus.K        = 17'd65536;
      repeat (2) next_cycle();

      check("rst_valid", bus.out_valid, 0);
      check("rst_ox",    bus.OX,        0);
      check("rst_oy",    bus.OY,        0);
      check("rst_rott",  bus.next_rott, 0);
      check("rst_k",     bus.next_K,    0);
      check("rst_done",  bus.done,      0);

      rst          = 1'b0;
      bus.in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         check($sformatf("rst_ignored_c%0d", c), bus.out_valid, 0);
      end

      foreach (vecs[i]) begin
`ifdef HYP_ROT_KSCALE_EN
         exp_k = vecs[i].nk;
`else
         exp_k = vecs[i].k;
`endif
         bus.in_valid = 1'b1;
         bus.IX       = 17'(vecs[i].ix);
         bus.IY       = 17'(vecs[i].iy);
         bus.rotation = 6'(vecs[i].r);
         bus.K        = 17'(vecs[i].k);
         next_cycle();
         bus.in_valid = 1'b0;
         next_cycle();
         check($sformatf("v%0d_early", i), bus.out_valid, 0);
         next_cycle();
         check($sformatf("v%0d_valid", i), bus.out_valid, 1);
         check($sformatf("v%0d_ox",    i), bus.OX,        vecs[i].ox);
         check($sformatf("v%0d_oy",    i), bus.OY,        vecs[i].oy);
         check($sformatf("v%0d_rott",  i), bus.next_rott, vecs[i].nr);
         check($sformatf("v%0d_k",     i), bus.next_K,    exp_k);
         check($sformatf("v%0d_done",  i), bus.done,      vecs[i].dn);
         next_cycle();
         check($sformatf("v%0d_bubble", i), bus.out_valid, 0);
         check($sformatf("v%0d_hold_ox", i), bus.OX,       vecs[i].ox);
         check($sformatf("v%0d_hold_k",  i), bus.next_K,   exp_k);
      end

      bus.IX       = 17'd65536;
      bus.IY       = 17'sd32768;
      bus.rotation = 6'd1;
      bus.K        = 17'd65536;
      for (int n = 0; n < 16; n++) begin
         bus.in_valid = vin[n];
         rst          = vrst[n];
         check($sformatf("stream_valid_c%0d", n), bus.out_valid, exp_valid(n));
         if (n == 9) begin
            check("stream_rst_ox",   bus.OX,        0);
            check("stream_rst_rott", bus.next_rott, 0);
         end
         if (n == 12)
            check("stream_fresh_ox", bus.OX, 49152);
         next_cycle();
      end
      rst          = 1'b0;
      bus.in_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
